// File: rtl/prefetch_fetch_queue.sv
// rtl/prefetch_fetch_queue.sv - instruction prefetch queue buffering {pc, instr} pairs ahead of decode
module prefetch_fetch_queue #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter int               PC_STEP  = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       halt_sys,
    input  logic                       redirect,
    input  logic [WIDTH-1:0]           redirect_pc,
    output logic [WIDTH-1:0]           imem_addr,
    input  logic [WIDTH-1:0]           imem_data,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [WIDTH-1:0]           deq_instr,
    output logic [WIDTH-1:0]           deq_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] fetch_pc;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic             push;
    logic             pop;

    // full comes from the registered count, so a same-cycle pop never frees a slot
    assign full      = (count == CW'(DEPTH));
    assign deq_valid = (count != '0);
    assign push      = !redirect && !halt_sys && !full;
    assign pop       = deq_valid && deq_ready;

    assign imem_addr = fetch_pc;
    assign deq_pc    = pc_mem[rd_ptr];
    assign deq_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (redirect) begin
            // a pop in this cycle still completes for the consumer; state just restarts
            fetch_pc <= redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= fetch_pc;
                instr_mem[wr_ptr] <= imem_data;
                wr_ptr            <= wr_ptr + PW'(1);
                fetch_pc          <= fetch_pc + WIDTH'(PC_STEP);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_prefetch_fetch_queue.sv
// tb/tb_prefetch_fetch_queue.sv - scoreboard testbench for prefetch_fetch_queue
module tb_prefetch_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_sys;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        deq_ready;
    logic        deq_valid;
    logic [15:0] deq_instr;
    logic [15:0] deq_pc;
    logic [2:0]  count;
    logic        full;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb[$];
    logic [15:0] m_pc;
    logic [15:0] exp_pc;

    always #5 clk = ~clk;

    assign imem_data = imem_addr ^ 16'hA5A5;

    prefetch_fetch_queue #(
        .WIDTH(16), .DEPTH(DEPTH), .PC_STEP(2), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .halt_sys(halt_sys), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
        .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_instr(deq_instr),
        .deq_pc(deq_pc), .count(count), .full(full)
    );

    // advance one cycle, updating the expected queue from the inputs currently driven
    task automatic tick();
        bit do_pop;
        bit do_push;
        if (rst) begin
            sb.delete();
            m_pc = 16'h0000;
        end else if (redirect) begin
            sb.delete();
            m_pc = redirect_pc;
        end else begin
            do_pop  = (sb.size() != 0) && deq_ready;
            do_push = !halt_sys && (sb.size() != DEPTH);
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                sb.push_back({m_pc, m_pc ^ 16'hA5A5});
                m_pc = m_pc + 16'd2;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; halt_sys = 1'b0; redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b1;
        tick(); tick();
        total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", deq_valid); end
        total++; if (deq_instr !== 16'h0) begin bad++; $display("FAIL reset_instr got=%h want=0000", deq_instr); end
        total++; if (deq_pc !== 16'h0) begin bad++; $display("FAIL reset_pc got=%h want=0000", deq_pc); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (imem_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h want=0000", imem_addr); end
    endtask

    task automatic test_stream();
        rst = 1'b0; deq_ready = 1'b1; exp_pc = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count got=%0d want=1", count); end
            total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL stream_addr got=%h want=%h", imem_addr, m_pc); end
            if (sb.size() != 0) begin
                total++;
                if (deq_valid !== 1'b1 || {deq_pc, deq_instr} !== sb[0] || deq_pc !== exp_pc) begin
                    bad++; $display("FAIL stream_head got=%b/%h/%h want=1/%h/%h", deq_valid, deq_pc, deq_instr, exp_pc, sb[0][15:0]);
                end
                exp_pc = exp_pc + 16'd2;
            end
        end
    endtask

    task automatic test_fill();
        rst = 1'b1; tick(); rst = 1'b0; deq_ready = 1'b0;
        repeat (8) tick();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", count); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", full); end
        total++; if (imem_addr !== 16'd8) begin bad++; $display("FAIL fill_addr got=%h want=0008", imem_addr); end
        deq_ready = 1'b1; exp_pc = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (deq_valid !== 1'b1 || sb.size() == 0 || {deq_pc, deq_instr} !== sb[0] || deq_pc !== exp_pc) begin
                bad++; $display("FAIL drain_head got=%b/%h/%h want=1/%h", deq_valid, deq_pc, deq_instr, exp_pc);
            end
            total++; if (count !== 3'(sb.size())) begin bad++; $display("FAIL drain_count got=%0d want=%0d", count, sb.size()); end
            exp_pc = exp_pc + 16'd2;
            tick();
        end
    endtask

    task automatic test_redirect();
        deq_ready = 1'b0;
        repeat (4) tick();
        total++; if (full !== 1'b1) begin bad++; $display("FAIL redir_prefull got=%b want=1", full); end
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL redir_count got=%0d want=0", count); end
        total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b want=0", deq_valid); end
        total++; if (imem_addr !== 16'h0100) begin bad++; $display("FAIL redir_addr got=%h want=0100", imem_addr); end
        tick();
        total++;
        if (deq_valid !== 1'b1 || deq_pc !== 16'h0100 || deq_instr !== (16'h0100 ^ 16'hA5A5)) begin
            bad++; $display("FAIL redir_head got=%b/%h/%h want=1/0100/%h", deq_valid, deq_pc, deq_instr, 16'h0100 ^ 16'hA5A5);
        end
    endtask

    task automatic test_halt();
        deq_ready = 1'b0;
        tick(); tick();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL halt_precount got=%0d want=3", count); end
        halt_sys = 1'b1; deq_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (sb.size() != 0) begin
                total++;
                if (deq_valid !== 1'b1 || {deq_pc, deq_instr} !== sb[0]) begin
                    bad++; $display("FAIL halt_head got=%b/%h want=1/%h", deq_valid, deq_pc, sb[0][31:16]);
                end
            end
            tick();
        end
        total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL halt_empty got=%b want=0", deq_valid); end
        total++; if (imem_addr !== 16'h0106) begin bad++; $display("FAIL halt_addr got=%h want=0106", imem_addr); end
        halt_sys = 1'b0;
        tick();
        total++;
        if (deq_valid !== 1'b1 || deq_pc !== 16'h0106) begin
            bad++; $display("FAIL halt_resume got=%b/%h want=1/0106", deq_valid, deq_pc);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 16'hFFFE; deq_ready = 1'b0;
        tick();
        redirect = 1'b0;
        repeat (3) tick();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL wrap_precount got=%0d want=3", count); end
        deq_ready = 1'b1; exp_pc = 16'hFFFE;
        for (int i = 0; i < 8; i++) begin
            total++; if (count !== 3'd3) begin bad++; $display("FAIL wrap_count got=%0d want=3", count); end
            total++;
            if (deq_valid !== 1'b1 || sb.size() == 0 || {deq_pc, deq_instr} !== sb[0] || deq_pc !== exp_pc) begin
                bad++; $display("FAIL wrap_head got=%b/%h/%h want=1/%h", deq_valid, deq_pc, deq_instr, exp_pc);
            end
            exp_pc = exp_pc + 16'd2;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        deq_ready = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL midrst_precount got=%0d want=3", count); end
        rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
        tick();
        rst = 1'b0; redirect = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", count); end
        total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", deq_valid); end
        total++; if (deq_instr !== 16'h0) begin bad++; $display("FAIL midrst_instr got=%h want=0000", deq_instr); end
        total++; if (imem_addr !== 16'h0) begin bad++; $display("FAIL midrst_addr got=%h want=0000", imem_addr); end
    endtask

    initial begin
        m_pc = 16'h0000;
        test_reset();
        test_stream();
        test_fill();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
